rng_word_collector: RTL

Consumer end of the NeoRNG byte stream. Gates the generator enable and issues reseed loads. Packs the validated random bytes into WORD_BYTES-wide little-endian words and buffers them in a small first-word-fall-through FIFO. Downstream simulation logic pulls the words with a ready/valid handshake.

---
 rtl/neorng_pkg.sv | 21 ++
 rtl/sync_fifo_fwft.sv | 69 ++++++
 rtl/rng_word_collector.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/neorng_pkg.sv
// Shared definitions for NeoRNG consumer blocks: byte width, collector FSM
// encoding and default packing/buffering sizes.
package neorng_pkg;

    localparam int BYTE_W         = 8;
    localparam int DEF_WORD_BYTES = 4;
    localparam int DEF_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_SEED = 2'd2,
        ST_WAIT = 2'd3
    } rng_state_e;

    // Index width for a byte lane counter; never narrower than one bit.
    function automatic int idx_width(input int n_bytes);
        return (n_bytes > 1) ? $clog2(n_bytes) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
// A push into a full FIFO only lands when a pop frees the head in the same cycle.
module sync_fifo_fwft #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_level
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_level;
    logic             w_pop;
    logic             w_push_ok;

    assign o_empty   = (r_level == CNT_W'(0));
    assign o_full    = (r_level == CNT_W'(DEPTH));
    assign o_level   = r_level;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_pop     = i_pop & ~o_empty;
    assign w_push_ok = i_push & (~o_full | w_pop);

    // Storage is cleared on reset so the head never shows X.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end else begin
            r_mem[r_wr_ptr] <= r_mem[r_wr_ptr];
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_level <= r_level + CNT_W'(1);
                2'b01:   r_level <= r_level - CNT_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/rng_word_collector.sv
// Consumer end of the NeoRNG byte stream: gates the generator, issues reseeds,
// packs bytes little-endian into words and buffers them for a ready/valid sink.
module rng_word_collector
    import neorng_pkg::*;
#(
    parameter int WORD_BYTES = DEF_WORD_BYTES,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         run_i,
    input  logic                         rng_valid_i,
    input  logic [BYTE_W-1:0]            rng_data_i,
    output logic                         rng_enable_o,
    output logic                         rng_load_o,
    output logic [BYTE_W-1:0]            rng_seed_o,
    input  logic                         seed_req_i,
    input  logic [BYTE_W-1:0]            seed_i,
    output logic                         seed_ack_o,
    output logic                         word_valid_o,
    output logic [BYTE_W*WORD_BYTES-1:0] word_data_o,
    input  logic                         word_ready_i,
    output logic [CNT_W-1:0]             fifo_level_o,
    output logic                         overrun_o
);

    localparam int IDX_W  = idx_width(WORD_BYTES);
    localparam int WORD_W = BYTE_W * WORD_BYTES;

    rng_state_e          r_state;
    rng_state_e          w_next_state;
    logic [IDX_W-1:0]    r_idx;
    logic [WORD_W-1:0]   r_word;
    logic [WORD_W-1:0]   w_word;
    logic [BYTE_W-1:0]   r_seed;
    logic                r_overrun;
    logic                w_capture;
    logic                w_last;
    logic                w_push;
    logic                w_pop;
    logic                w_drop;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic [CNT_W-1:0]    w_level;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; a reseed request outranks run_i.
    always_comb begin
        w_next_state = ST_IDLE;
        case (r_state)
            ST_IDLE: begin
                if (seed_req_i)  w_next_state = ST_SEED;
                else if (run_i)  w_next_state = ST_RUN;
                else             w_next_state = ST_IDLE;
            end
            ST_RUN: begin
                if (seed_req_i)  w_next_state = ST_SEED;
                else if (!run_i) w_next_state = ST_IDLE;
                else             w_next_state = ST_RUN;
            end
            ST_SEED: w_next_state = ST_WAIT;
            ST_WAIT: begin
                if (run_i)       w_next_state = ST_RUN;
                else             w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Generator controls; one slot of slack absorbs bytes already in flight.
    always_comb begin
        rng_enable_o = 1'b0;
        rng_load_o   = 1'b0;
        seed_ack_o   = 1'b0;
        case (r_state)
            ST_RUN:  rng_enable_o = (w_level < CNT_W'(FIFO_DEPTH - 1));
            ST_SEED: begin
                rng_load_o = 1'b1;
                seed_ack_o = 1'b1;
            end
            default: rng_enable_o = 1'b0;
        endcase
    end

    // Seed byte is latched on entry to SEED so it is presented from a register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seed <= 8'h00;
        end else if (w_next_state == ST_SEED) begin
            r_seed <= seed_i;
        end else begin
            r_seed <= 8'h00;
        end
    end

    assign rng_seed_o = r_seed;

    // IDLE still accepts a straggler byte that was in flight when run_i dropped.
    assign w_capture = rng_valid_i & ((r_state == ST_RUN) | (r_state == ST_IDLE));
    assign w_last    = (r_idx == IDX_W'(WORD_BYTES - 1));
    assign w_push    = w_capture & w_last;

    // Merge the incoming byte into its lane of the partial word.
    always_comb begin
        w_word = r_word;
        w_word[int'(r_idx)*BYTE_W +: BYTE_W] = rng_data_i;
    end

    // Byte lane index and partial word; a reseed restarts the word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx  <= '0;
            r_word <= '0;
        end else if (r_state == ST_SEED) begin
            r_idx  <= '0;
            r_word <= r_word;
        end else if (w_capture) begin
            r_word <= w_word;
            r_idx  <= w_last ? '0 : r_idx + IDX_W'(1);
        end else begin
            r_idx  <= r_idx;
            r_word <= r_word;
        end
    end

    assign w_pop  = word_ready_i & ~w_fifo_empty;
    assign w_drop = w_push & w_fifo_full & ~w_pop;

    // Sticky record of any completed word lost to a full FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= r_overrun | w_drop;
        end
    end

    assign overrun_o = r_overrun;

    sync_fifo_fwft #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (w_word),
        .i_pop       (w_pop),
        .o_head      (word_data_o),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_level     (w_level)
    );

    assign word_valid_o = ~w_fifo_empty;
    assign fifo_level_o = w_level;

endmodule
